fft_deserializer: RTL

FFT_DESERIALIZER -- requirements
Module: fft_deserializer

---
 rtl/fft_deserializer_if.sv | 44 ++++
 rtl/fft_deserializer.sv | 115 +++++++++++
 2 files changed

// File: rtl/fft_deserializer_if.sv
// Bus bundle for the FFT deserializer.
// The serial side carries one complex sample per transfer.
// The parallel side carries a whole frame of N_SAMPLES complex samples.
// "master" is the environment around the block; "slave" is the deserializer.
interface fft_deserializer_if #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
);

   // Serial input side
   logic [BIT_WIDTH-1:0] recv_msg_real;
   logic [BIT_WIDTH-1:0] recv_msg_imag;
   logic                 recv_val;
   logic                 recv_rdy;

   // Parallel output side (index 0 .. N_SAMPLES-1)
   logic [BIT_WIDTH-1:0] send_msg_real [N_SAMPLES];
   logic [BIT_WIDTH-1:0] send_msg_imag [N_SAMPLES];
   logic                 send_val;
   logic                 send_rdy;

   modport master (
      output recv_msg_real,
      output recv_msg_imag,
      output recv_val,
      input  recv_rdy,
      input  send_msg_real,
      input  send_msg_imag,
      input  send_val,
      output send_rdy
   );

   modport slave (
      input  recv_msg_real,
      input  recv_msg_imag,
      input  recv_val,
      output recv_rdy,
      output send_msg_real,
      output send_msg_imag,
      output send_val,
      input  send_rdy
   );

endinterface : fft_deserializer_if

// File: rtl/fft_deserializer.sv
// Serial-to-parallel frame builder in front of an FFT stage.
// Collects N_SAMPLES complex samples in natural order (FILL), then presents
// the whole frame until the downstream stage takes it (SEND). The frame
// hand-off costs one cycle, so a steady stream yields one frame every
// N_SAMPLES+1 cycles. Both handshake outputs come straight from the state
// register, so there is no combinational path from recv_val or send_rdy.
module fft_deserializer #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8   // power of two, at least 2
) (
   input  logic                 clk,
   input  logic                 reset,   // synchronous, active-high
   fft_deserializer_if.slave    bus
);

   localparam int CNT_W = $clog2(N_SAMPLES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

   typedef enum logic {
      FILL = 1'b0,   // collecting serial samples
      SEND = 1'b1    // full frame held for the downstream stage
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [CNT_W-1:0]     cnt_q;     // next write index within the frame
   logic [CNT_W-1:0]     cnt_d;

   logic                 recv_rdy;
   logic                 send_val;
   logic                 recv_xfer;
   logic                 send_xfer;

   logic [BIT_WIDTH-1:0] real_q [N_SAMPLES];
   logic [BIT_WIDTH-1:0] imag_q [N_SAMPLES];

   // Handshake outputs decoded from the registered state only
   always_comb begin
      recv_rdy = (state_q == FILL);
      send_val = (state_q == SEND);
   end

   // A transfer on either side needs both valid and ready high
   always_comb begin
      recv_xfer = bus.recv_val && recv_rdy;
      send_xfer = send_val && bus.send_rdy;
   end

   // Next-state and next-index logic
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch can be inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         FILL: begin
            // send_rdy is irrelevant here; only serial transfers matter
            if (recv_xfer) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = SEND;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         SEND: begin
            // recv_val is irrelevant here; recv_rdy is low so nothing is taken
            if (send_xfer) begin
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = FILL;
         end
      endcase
   end

   // State and counter registers; reset wins over any transfer
   always_ff @(posedge clk) begin
      // NOTE: clocked state is updated with non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      if (reset) begin
         state_q <= FILL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Frame storage: write accepted sample at the current index
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the frame storage is reset on purpose: a cleared frame is
         // visible on the outputs and a stale frame must not leak past reset.
         for (int k = 0; k < N_SAMPLES; k++) begin
            real_q[k] <= '0;
            imag_q[k] <= '0;
         end
      end else if (recv_xfer) begin
         // Entries not addressed keep their values from the previous frame
         real_q[cnt_q] <= bus.recv_msg_real;
         imag_q[cnt_q] <= bus.recv_msg_imag;
      end
   end

   assign bus.recv_rdy      = recv_rdy;
   assign bus.send_val      = send_val;
   assign bus.send_msg_real = real_q;
   assign bus.send_msg_imag = imag_q;

endmodule : fft_deserializer
